// File: rtl/ts_packet_sender_pkg.sv
// Shared constants, register map and state encoding for the TS packet sender.
package ts_packet_sender_pkg;

    localparam int C_S_AXI_DATA_WIDTH = 32;
    localparam int OPT_MEM_ADDR_BITS  = 10;

    localparam logic [10:0] ADDR_CMD       = 11'd0;
    localparam logic [10:0] ADDR_REPEAT    = 11'd1;
    localparam logic [10:0] ADDR_GAP       = 11'd2;
    localparam logic [10:0] ADDR_DIV       = 11'd3;
    localparam logic [10:0] ADDR_STATUS    = 11'd4;
    localparam logic [10:0] ADDR_BUF_FIRST = 11'd128;
    localparam logic [10:0] ADDR_BUF_LAST  = 11'd174;

    localparam logic [31:0] CMD_START      = 32'd1;
    localparam logic [31:0] CMD_STOP       = 32'd2;
    localparam logic [31:0] UNMAPPED_RDATA = 32'hFF00_FF00;

    localparam int PACK_BYTE_SIZE = 188;
    localparam int PACK_WORD_SIZE = 47;
    localparam logic [7:0] PACK_END = 8'(PACK_BYTE_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } ts_state_t;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                 input logic [31:0] new_val,
                                                 input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) merged[8*i +: 8] = new_val[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/ts_packet_sender_if.sv
// Register-bus bundle between the AXI-lite front end and the TS packet sender.
interface ts_packet_sender_if;
    import ts_packet_sender_pkg::*;

    logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic                            mem_wren;
    logic                            mem_rden;
    logic [OPT_MEM_ADDR_BITS:0]      mem_address;
    logic [C_S_AXI_DATA_WIDTH-1:0]   axi_rdata;

    modport master (
        output S_AXI_WSTRB, S_AXI_WDATA, mem_wren, mem_rden, mem_address,
        input  axi_rdata
    );

    modport slave (
        input  S_AXI_WSTRB, S_AXI_WDATA, mem_wren, mem_rden, mem_address,
        output axi_rdata
    );

endinterface

// File: rtl/ts_byte_timer.sv
// Byte-slot timer: a slot lasts div+1 clocks, tick marks each slot's first clock.
module ts_byte_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [7:0] div,
    output logic       tick
);

    logic [7:0] count;

    // Held at zero while stopped so the first slot starts on the first running clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (!run || count == div) begin
            count <= 8'd0;
        end else begin
            count <= count + 8'd1;
        end
    end

    assign tick = run && (count == 8'd0);

endmodule

// File: rtl/ts_packet_sender.sv
// Transmits a 188-byte TS packet from a register-loaded buffer, with repeat, gap and rate control.
module ts_packet_sender
    import ts_packet_sender_pkg::*;
(
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESETN,
    ts_packet_sender_if.slave bus,
    output logic [7:0]        ts_out,
    output logic              ts_out_valid,
    output logic              ts_out_sync,
    output logic              busy
);

    ts_state_t   state, state_next;
    logic [31:0] cmd_reg, repeat_reg, cmd_next, rd_word, reg_rdata;
    logic [7:0]  gap_reg, div_reg, byte_idx, idx_next, emit_idx, gap_cnt, gap_next;
    logic [15:0] sent_count, count_inc;
    logic [5:0]  buf_word;
    logic [1:0]  byte_sel;
    logic        stop_pending, tick, emit, pkt_done, reached, tx_active, rd_sel_buf;
    logic        cmd_wr, start_cmd, stop_cmd, in_buf;
    logic [31:0] buffer [PACK_WORD_SIZE];

    assign busy      = (state != ST_IDLE);
    assign in_buf    = (bus.mem_address >= ADDR_BUF_FIRST) && (bus.mem_address <= ADDR_BUF_LAST);
    assign buf_word  = 6'(bus.mem_address - ADDR_BUF_FIRST);
    assign cmd_wr    = bus.mem_wren && (bus.mem_address == ADDR_CMD);
    assign cmd_next  = apply_wstrb(cmd_reg, bus.S_AXI_WDATA, bus.S_AXI_WSTRB);
    assign start_cmd = cmd_wr && (cmd_next == CMD_START);
    assign stop_cmd  = cmd_wr && (cmd_next == CMD_STOP);
    assign count_inc = (sent_count == 16'hFFFF) ? sent_count : sent_count + 16'd1;
    assign reached   = (repeat_reg != 32'd0) && ({16'd0, count_inc} == repeat_reg);

    ts_byte_timer u_timer (
        .clk   (S_AXI_ACLK),
        .rst_n (S_AXI_ARESETN),
        .run   (busy),
        .div   (div_reg),
        .tick  (tick)
    );

    // byte_idx == PACK_END means byte 187's slot is running; the next tick ends the packet.
    always_comb begin
        state_next = state;
        idx_next   = byte_idx;
        gap_next   = gap_cnt;
        emit       = 1'b0;
        emit_idx   = byte_idx;
        pkt_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_cmd) begin
                    state_next = ST_SEND;
                    idx_next   = 8'd0;
                end
            end
            ST_SEND: begin
                if (tick) begin
                    if (byte_idx == PACK_END) begin
                        pkt_done = 1'b1;
                        if (stop_pending || reached) begin
                            state_next = ST_IDLE;
                        end else if (gap_reg == 8'd0) begin
                            emit     = 1'b1;
                            emit_idx = 8'd0;
                            idx_next = 8'd1;
                        end else begin
                            state_next = ST_GAP;
                            gap_next   = gap_reg - 8'd1;
                            idx_next   = 8'd0;
                        end
                    end else begin
                        emit     = 1'b1;
                        idx_next = byte_idx + 8'd1;
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (stop_pending) begin
                        state_next = ST_IDLE;
                    end else if (gap_cnt == 8'd0) begin
                        state_next = ST_SEND;
                        emit       = 1'b1;
                        emit_idx   = 8'd0;
                        idx_next   = 8'd1;
                    end else begin
                        gap_next = gap_cnt - 8'd1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state        <= ST_IDLE;
            byte_idx     <= 8'd0;
            gap_cnt      <= 8'd0;
            cmd_reg      <= 32'd0;
            repeat_reg   <= 32'd0;
            gap_reg      <= 8'd0;
            div_reg      <= 8'd0;
            sent_count   <= 16'd0;
            stop_pending <= 1'b0;
        end else begin
            state    <= state_next;
            byte_idx <= idx_next;
            gap_cnt  <= gap_next;
            if (cmd_wr) cmd_reg <= cmd_next;
            if (bus.mem_wren && !busy) begin
                if (bus.mem_address == ADDR_REPEAT)
                    repeat_reg <= apply_wstrb(repeat_reg, bus.S_AXI_WDATA, bus.S_AXI_WSTRB);
                if (bus.mem_address == ADDR_GAP && bus.S_AXI_WSTRB[0])
                    gap_reg <= bus.S_AXI_WDATA[7:0];
                if (bus.mem_address == ADDR_DIV && bus.S_AXI_WSTRB[0])
                    div_reg <= bus.S_AXI_WDATA[7:0];
            end
            if (start_cmd && !busy) begin
                sent_count   <= 16'd0;
                stop_pending <= 1'b0;
            end else begin
                if (pkt_done) sent_count <= count_inc;
                if (busy && state_next == ST_IDLE) stop_pending <= 1'b0;
                else if (stop_cmd && busy)         stop_pending <= 1'b1;
            end
        end
    end

    // Single read port: the transmitter owns it while busy, the register bus while idle.
    always_ff @(posedge S_AXI_ACLK) begin
        if (bus.mem_wren && in_buf && !busy) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.S_AXI_WSTRB[i]) buffer[buf_word][8*i +: 8] <= bus.S_AXI_WDATA[8*i +: 8];
            end
        end
        if (emit) begin
            rd_word <= buffer[emit_idx[7:2]];
        end else if (bus.mem_rden && in_buf && !busy) begin
            rd_word <= buffer[buf_word];
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ts_out_valid <= 1'b0;
            ts_out_sync  <= 1'b0;
            tx_active    <= 1'b0;
            byte_sel     <= 2'd0;
        end else begin
            ts_out_valid <= emit;
            if (tick || !busy) begin
                tx_active   <= emit;
                ts_out_sync <= emit && (emit_idx == 8'd0);
                byte_sel    <= emit_idx[1:0];
            end
        end
    end

    always_comb begin
        ts_out = 8'h00;
        if (tx_active) ts_out = rd_word[8*byte_sel +: 8];
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            reg_rdata  <= 32'd0;
            rd_sel_buf <= 1'b0;
        end else if (bus.mem_rden) begin
            rd_sel_buf <= in_buf;
            case (bus.mem_address)
                ADDR_CMD:    reg_rdata <= cmd_reg;
                ADDR_REPEAT: reg_rdata <= repeat_reg;
                ADDR_GAP:    reg_rdata <= {24'd0, gap_reg};
                ADDR_DIV:    reg_rdata <= {24'd0, div_reg};
                ADDR_STATUS: reg_rdata <= {sent_count, 14'd0, stop_pending, busy};
                default:     reg_rdata <= UNMAPPED_RDATA;
            endcase
        end
    end

    assign bus.axi_rdata = rd_sel_buf ? rd_word : reg_rdata;

endmodule

// File: tb/tb_ts_packet_sender.sv
// Directed self-checking bench for ts_packet_sender.
module tb_ts_packet_sender;

    typedef struct {
        logic [7:0] data;
        logic       sync;
        int         cyc;
    } pulse_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ts_out;
    logic       ts_out_valid, ts_out_sync, busy;

    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    int     last_wr_cyc = 0;
    int     sync_cycles = 0;
    pulse_t mon_q[$];
    pulse_t mon_p;

    ts_packet_sender_if bus();

    ts_packet_sender dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .bus           (bus),
        .ts_out        (ts_out),
        .ts_out_valid  (ts_out_valid),
        .ts_out_sync   (ts_out_sync),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every slot-start strobe with its byte, sync flag and cycle number.
    always @(negedge clk) begin
        if (ts_out_valid === 1'b1) begin
            mon_p.data = ts_out;
            mon_p.sync = ts_out_sync;
            mon_p.cyc  = cyc;
            mon_q.push_back(mon_p);
        end
        if (ts_out_sync === 1'b1) sync_cycles++;
    end

    task automatic bus_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s);
        @(posedge clk); #1;
        bus.mem_address = a;
        bus.S_AXI_WDATA = d;
        bus.S_AXI_WSTRB = s;
        bus.mem_wren    = 1'b1;
        last_wr_cyc     = cyc;
        @(posedge clk); #1;
        bus.mem_wren    = 1'b0;
    endtask

    task automatic bus_read(input logic [10:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        bus.mem_address = a;
        bus.mem_rden    = 1'b1;
        @(posedge clk); #1;
        bus.mem_rden    = 1'b0;
        d = bus.axi_rdata;
    endtask

    task automatic wait_idle(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_pulses(input int n, input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (mon_q.size() >= n) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic load_buffer();
        logic [31:0] w;
        for (int k = 0; k < 47; k++) begin
            w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            bus_write(11'(128 + k), w, 4'hF);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ts_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_ts_out got=%h exp=00", ts_out); end
        checks++; if (ts_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=0", ts_out_valid); end
        checks++; if (ts_out_sync !== 1'b0) begin errors++; $display("[TB] FAIL reset_sync got=%b exp=0", ts_out_sync); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (bus.axi_rdata !== 32'd0) begin errors++; $display("[TB] FAIL reset_rdata got=%h exp=0", bus.axi_rdata); end
        rst_n = 1'b1;
        bus_read(11'd1, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("[TB] FAIL reset_repeat got=%h exp=0", rd); end
        bus_read(11'd2, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("[TB] FAIL reset_gap got=%h exp=0", rd); end
        bus_read(11'd3, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("[TB] FAIL reset_div got=%h exp=0", rd); end
        bus_read(11'd4, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("[TB] FAIL reset_status got=%h exp=0", rd); end
    endtask

    task automatic test_single_packet();
        logic [31:0] rd;
        bit          to;
        int          bad, start_cyc, lat;
        bus_write(11'd1, 32'd1, 4'hF);
        bus_write(11'd2, 32'd0, 4'hF);
        bus_write(11'd3, 32'd0, 4'hF);
        mon_q.delete();
        sync_cycles = 0;
        bus_write(11'd0, 32'd1, 4'hF);
        start_cyc = last_wr_cyc;
        wait_idle(1000, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL single_timeout got=busy exp=idle"); end
        checks++; if (mon_q.size() !== 188) begin errors++; $display("[TB] FAIL single_count got=%0d exp=188", mon_q.size()); end
        lat = (mon_q.size() > 0) ? mon_q[0].cyc - start_cyc : -1;
        checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL single_latency got=%0d exp=2", lat); end
        bad = 0;
        for (int i = 0; i < mon_q.size(); i++) begin
            if (mon_q[i].data !== 8'(i) || mon_q[i].sync !== (i == 0)) bad++;
            if (mon_q[i].cyc !== mon_q[0].cyc + i) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL single_content got=%0d_bad exp=0_bad", bad); end
        checks++; if (sync_cycles !== 1) begin errors++; $display("[TB] FAIL single_sync_len got=%0d exp=1", sync_cycles); end
        bus_read(11'd4, rd);
        checks++; if (rd !== 32'h0001_0000) begin errors++; $display("[TB] FAIL single_status got=%h exp=00010000", rd); end
    endtask

    task automatic test_gap_repeat();
        logic [31:0] rd;
        bit          to;
        int          bad, step;
        bus_write(11'd1, 32'd2, 4'hF);
        bus_write(11'd2, 32'd2, 4'hF);
        bus_write(11'd3, 32'd3, 4'hF);
        mon_q.delete();
        sync_cycles = 0;
        bus_write(11'd0, 32'd1, 4'hF);
        wait_idle(4000, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL gap_timeout got=busy exp=idle"); end
        checks++; if (mon_q.size() !== 376) begin errors++; $display("[TB] FAIL gap_count got=%0d exp=376", mon_q.size()); end
        bad = 0;
        for (int i = 0; i < mon_q.size(); i++) begin
            if (mon_q[i].data !== 8'(i % 188) || mon_q[i].sync !== ((i % 188) == 0)) bad++;
            if (i > 0) begin
                step = (i == 188) ? 12 : 4;
                if (mon_q[i].cyc - mon_q[i-1].cyc !== step) bad++;
            end
        end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL gap_content got=%0d_bad exp=0_bad", bad); end
        checks++; if (sync_cycles !== 8) begin errors++; $display("[TB] FAIL gap_sync_len got=%0d exp=8", sync_cycles); end
        bus_read(11'd4, rd);
        checks++; if (rd !== 32'h0002_0000) begin errors++; $display("[TB] FAIL gap_status got=%h exp=00020000", rd); end
    endtask

    task automatic test_stop();
        logic [31:0] rd;
        bit          to;
        int          bad;
        bus_write(11'd1, 32'd0, 4'hF);
        bus_write(11'd2, 32'd0, 4'hF);
        bus_write(11'd3, 32'd3, 4'hF);
        mon_q.delete();
        bus_write(11'd0, 32'd1, 4'hF);
        wait_pulses(51, 1000, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL stop_reach50 got=timeout exp=byte50"); end
        bus_write(11'd0, 32'd2, 4'hF);
        bus_read(11'd4, rd);
        checks++; if (rd[1:0] !== 2'b11) begin errors++; $display("[TB] FAIL stop_pending got=%b exp=11", rd[1:0]); end
        wait_idle(2000, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL stop_timeout got=busy exp=idle"); end
        checks++; if (mon_q.size() !== 188) begin errors++; $display("[TB] FAIL stop_count got=%0d exp=188", mon_q.size()); end
        bad = 0;
        for (int i = 0; i < mon_q.size(); i++) begin
            if (mon_q[i].data !== 8'(i)) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL stop_content got=%0d_bad exp=0_bad", bad); end
        bus_read(11'd4, rd);
        checks++; if (rd[31:16] !== 16'd1 || rd[0] !== 1'b0) begin errors++; $display("[TB] FAIL stop_status got=%h exp=0001xxx0", rd); end
    endtask

    task automatic test_busy_restart();
        logic [31:0] rd;
        bit          to;
        int          bad;
        bus_read(11'd5, rd);
        checks++; if (rd !== 32'hFF00_FF00) begin errors++; $display("[TB] FAIL unmapped5 got=%h exp=ff00ff00", rd); end
        bus_read(11'h7FF, rd);
        checks++; if (rd !== 32'hFF00_FF00) begin errors++; $display("[TB] FAIL unmapped7ff got=%h exp=ff00ff00", rd); end
        bus_write(11'd1, 32'd2, 4'hF);
        bus_write(11'd2, 32'd0, 4'hF);
        bus_write(11'd3, 32'd0, 4'hF);
        mon_q.delete();
        bus_write(11'd0, 32'd1, 4'hF);
        wait_pulses(201, 1000, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL restart_reach got=timeout exp=pkt2"); end
        bus_read(11'd4, rd);
        checks++; if (rd[31:16] !== 16'd1) begin errors++; $display("[TB] FAIL restart_count_before got=%0d exp=1", rd[31:16]); end
        bus_write(11'd0, 32'd1, 4'hF);
        bus_read(11'd4, rd);
        checks++; if (rd[31:16] !== 16'd1) begin errors++; $display("[TB] FAIL restart_count_after got=%0d exp=1", rd[31:16]); end
        wait_idle(2000, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL restart_timeout got=busy exp=idle"); end
        checks++; if (mon_q.size() !== 376) begin errors++; $display("[TB] FAIL restart_total got=%0d exp=376", mon_q.size()); end
        bad = 0;
        for (int i = 0; i < mon_q.size(); i++) begin
            if (mon_q[i].data !== 8'(i % 188)) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL restart_content got=%0d_bad exp=0_bad", bad); end
        bus_read(11'd4, rd);
        checks++; if (rd[31:16] !== 16'd2) begin errors++; $display("[TB] FAIL restart_final got=%0d exp=2", rd[31:16]); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        bit          to;
        bus_write(11'd1, 32'd0, 4'hF);
        bus_write(11'd2, 32'd0, 4'hF);
        bus_write(11'd3, 32'd0, 4'hF);
        mon_q.delete();
        bus_write(11'd0, 32'd1, 4'hF);
        wait_pulses(101, 1000, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL rstmid_reach got=timeout exp=byte100"); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ts_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid got=%b exp=0", ts_out_valid); end
        checks++; if (ts_out !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_ts_out got=%h exp=00", ts_out); end
        checks++; if (ts_out_sync !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_sync got=%b exp=0", ts_out_sync); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy got=%b exp=0", busy); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus_read(11'd4, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("[TB] FAIL rstmid_status got=%h exp=0", rd); end
        bus_write(11'd128, 32'h0302_0100, 4'hF);
        bus_write(11'd1, 32'd1, 4'hF);
        mon_q.delete();
        bus_write(11'd0, 32'd1, 4'hF);
        wait_idle(1000, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL rstmid_timeout got=busy exp=idle"); end
        checks++; if (mon_q.size() !== 188) begin errors++; $display("[TB] FAIL rstmid_count got=%0d exp=188", mon_q.size()); end
        checks++;
        if (mon_q.size() == 0 || mon_q[0].data !== 8'h00 || mon_q[0].sync !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstmid_first got=%0d_pulses exp=byte0_with_sync", mon_q.size());
        end
    endtask

    task automatic test_strobe();
        logic [31:0] rd;
        bit          to;
        bus_write(11'd128, 32'h0000_0000, 4'hF);
        bus_write(11'd128, 32'hAABB_CCDD, 4'b0010);
        bus_read(11'd128, rd);
        checks++; if (rd !== 32'h0000_CC00) begin errors++; $display("[TB] FAIL strobe_byte1 got=%h exp=0000cc00", rd); end
        bus_read(11'd0, rd);
        checks++; if (rd !== 32'd1) begin errors++; $display("[TB] FAIL cmd_readback got=%h exp=1", rd); end
        bus_write(11'd1, 32'd0, 4'hF);
        bus_write(11'd3, 32'd3, 4'hF);
        bus_write(11'd0, 32'd1, 4'hF);
        bus_write(11'd129, 32'h1234_5678, 4'hF);
        bus_write(11'd1, 32'd5, 4'hF);
        bus_write(11'd0, 32'd2, 4'hF);
        wait_idle(2000, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL strobe_timeout got=busy exp=idle"); end
        bus_read(11'd129, rd);
        checks++; if (rd !== 32'h0706_0504) begin errors++; $display("[TB] FAIL busy_buf_write got=%h exp=07060504", rd); end
        bus_read(11'd1, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("[TB] FAIL busy_repeat_write got=%h exp=0", rd); end
    endtask

    initial begin
        bus.mem_wren    = 1'b0;
        bus.mem_rden    = 1'b0;
        bus.mem_address = 11'd0;
        bus.S_AXI_WDATA = 32'd0;
        bus.S_AXI_WSTRB = 4'h0;
        test_reset();
        load_buffer();
        test_single_packet();
        test_gap_repeat();
        test_stop();
        test_busy_restart();
        test_reset_mid();
        test_strobe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
